// File: rtl/rv32_pipe_pkg.sv
// Shared pipeline types for the RV32I core: forwarding select encodings and
// the per-stage destination tracking record used by the hazard controller.
package rv32_pipe_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  is_load;
   } slot_t;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic                  rs1_used;
      logic                  rs2_used;
   } src_t;

   // x0 is hardwired to zero, so a write to it never produces a value to track.
   function automatic logic writes(slot_t s);
      return s.valid & s.reg_write & (s.rd != '0);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on i_inc and sticks at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // NOTE: count_d gets a default before any condition, so no latch is inferred.
   always_comb begin
      count_d = count_q;
      if (i_inc && (count_q != '1)) count_d = count_q + 1'b1;
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) count_q <= '0;
      else          count_q <= count_d;
   end

   assign o_count = count_q;

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage sequencing: tracks rd of EX/MEM/WB, drives operand forwarding,
// load-use stalls and branch flushes, and counts stall/flush events.
module ex_hazard_ctrl #(
   parameter int REG_ADDR_W = rv32_pipe_pkg::REG_ADDR_W,
   parameter int CNT_W      = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_hold,
   input  logic                  i_id_valid,
   input  logic [REG_ADDR_W-1:0] i_id_rs1,
   input  logic [REG_ADDR_W-1:0] i_id_rs2,
   input  logic                  i_id_rs1_used,
   input  logic                  i_id_rs2_used,
   input  logic [REG_ADDR_W-1:0] i_id_rd,
   input  logic                  i_id_reg_write,
   input  logic                  i_id_is_load,
   input  logic                  i_branch_taken,
   output logic                  o_stall,
   output logic                  o_flush,
   output logic [1:0]            o_fwd_a,
   output logic [1:0]            o_fwd_b,
   output logic [CNT_W-1:0]      o_stall_cnt,
   output logic [CNT_W-1:0]      o_flush_cnt
);

   import rv32_pipe_pkg::*;

   slot_t ex_q, ex_d;
   slot_t mem_q, mem_d;
   slot_t wb_q, wb_d;
   src_t  ex_src_q, ex_src_d;

   logic load_use;
   logic do_flush;
   logic do_stall;

   function automatic logic [1:0] fwd_sel(logic used, logic [REG_ADDR_W-1:0] rs);
      if (!ex_q.valid || !used)                fwd_sel = FWD_RF;
      else if (writes(mem_q) && mem_q.rd == rs) fwd_sel = FWD_MEM;
      else if (writes(wb_q) && wb_q.rd == rs)   fwd_sel = FWD_WB;
      else                                     fwd_sel = FWD_RF;
   endfunction

   always_comb begin
      load_use = writes(ex_q) & ex_q.is_load & i_id_valid &
                 ((i_id_rs1_used & (i_id_rs1 == ex_q.rd)) |
                  (i_id_rs2_used & (i_id_rs2 == ex_q.rd)));
      do_flush = !i_hold & i_branch_taken;
      do_stall = !i_hold & !i_branch_taken & load_use;
      o_stall  = i_hold | do_stall;
      o_flush  = do_flush;
      o_fwd_a  = fwd_sel(ex_src_q.rs1_used, ex_src_q.rs1);
      o_fwd_b  = fwd_sel(ex_src_q.rs2_used, ex_src_q.rs2);
   end

   always_comb begin
      ex_d     = ex_q;
      ex_src_d = ex_src_q;
      mem_d    = mem_q;
      wb_d     = wb_q;
      if (!i_hold) begin
         mem_d = ex_q;
         wb_d  = mem_q;
         if (do_flush || do_stall) begin
            ex_d.valid = 1'b0;
         end else begin
            ex_d     = '{valid: i_id_valid, rd: i_id_rd, reg_write: i_id_reg_write,
                         is_load: i_id_is_load};
            ex_src_d = '{rs1: i_id_rs1, rs2: i_id_rs2, rs1_used: i_id_rs1_used,
                         rs2_used: i_id_rs2_used};
         end
      end
   end

   // NOTE: only the valid bits matter after reset; clearing whole slots just keeps X out of the datapath.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ex_q     <= '0;
         ex_src_q <= '0;
         mem_q    <= '0;
         wb_q     <= '0;
      end else begin
         ex_q     <= ex_d;
         ex_src_q <= ex_src_d;
         mem_q    <= mem_d;
         wb_q     <= wb_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (do_stall),
      .o_count (o_stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (do_flush),
      .o_count (o_flush_cnt)
   );

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: instruction-level pipeline model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ex_hazard_ctrl;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_hold = 1'b0;
   logic       i_id_valid = 1'b0;
   logic [4:0] i_id_rs1 = '0;
   logic [4:0] i_id_rs2 = '0;
   logic       i_id_rs1_used = 1'b0;
   logic       i_id_rs2_used = 1'b0;
   logic [4:0] i_id_rd = '0;
   logic       i_id_reg_write = 1'b0;
   logic       i_id_is_load = 1'b0;
   logic       i_branch_taken = 1'b0;
   logic       o_stall;
   logic       o_flush;
   logic [1:0] o_fwd_a;
   logic [1:0] o_fwd_b;
   logic [CNT_W-1:0] o_stall_cnt;
   logic [CNT_W-1:0] o_flush_cnt;

   int vectors = 0;
   int miscompares = 0;

   ex_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_hold         (i_hold),
      .i_id_valid     (i_id_valid),
      .i_id_rs1       (i_id_rs1),
      .i_id_rs2       (i_id_rs2),
      .i_id_rs1_used  (i_id_rs1_used),
      .i_id_rs2_used  (i_id_rs2_used),
      .i_id_rd        (i_id_rd),
      .i_id_reg_write (i_id_reg_write),
      .i_id_is_load   (i_id_is_load),
      .i_branch_taken (i_branch_taken),
      .o_stall        (o_stall),
      .o_flush        (o_flush),
      .o_fwd_a        (o_fwd_a),
      .o_fwd_b        (o_fwd_b),
      .o_stall_cnt    (o_stall_cnt),
      .o_flush_cnt    (o_flush_cnt)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction-level model: index 0 = EX, 1 = MEM, 2 = WB.
   typedef struct {
      bit v;
      int rd;
      bit w;
      bit ld;
      int rs1;
      int rs2;
      bit u1;
      bit u2;
   } ins_t;

   ins_t m_pipe[3] = '{default: '{default: 0}};
   int   m_stall_cnt = 0;
   int   m_flush_cnt = 0;

   function automatic bit m_writes(ins_t x);
      return x.v && x.w && x.rd != 0;
   endfunction

   function automatic bit m_load_use();
      ins_t e = m_pipe[0];
      return m_writes(e) && e.ld && i_id_valid &&
             ((i_id_rs1_used && int'(i_id_rs1) == e.rd) ||
              (i_id_rs2_used && int'(i_id_rs2) == e.rd));
   endfunction

   // Youngest older producer wins: MEM (distance 1) before WB (distance 2).
   function automatic int m_fwd(bit used, int src);
      if (!m_pipe[0].v || !used) return 0;
      for (int k = 1; k <= 2; k++)
         if (m_writes(m_pipe[k]) && m_pipe[k].rd == src) return k;
      return 0;
   endfunction

   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < 3; k++) m_pipe[k] <= '{default: 0};
         m_stall_cnt <= 0;
         m_flush_cnt <= 0;
      end else if (!i_hold) begin
         m_pipe[2] <= m_pipe[1];
         m_pipe[1] <= m_pipe[0];
         if (i_branch_taken) begin
            m_pipe[0].v <= 1'b0;
            m_flush_cnt <= (m_flush_cnt < CNT_MAX) ? m_flush_cnt + 1 : m_flush_cnt;
         end else if (m_load_use()) begin
            m_pipe[0].v <= 1'b0;
            m_stall_cnt <= (m_stall_cnt < CNT_MAX) ? m_stall_cnt + 1 : m_stall_cnt;
         end else begin
            m_pipe[0] <= '{v: i_id_valid, rd: int'(i_id_rd), w: i_id_reg_write,
                           ld: i_id_is_load, rs1: int'(i_id_rs1), rs2: int'(i_id_rs2),
                           u1: i_id_rs1_used, u2: i_id_rs2_used};
         end
      end
   end

   always @(negedge i_clk) begin
      bit exp_stall;
      bit exp_flush;
      exp_flush = !i_hold && i_branch_taken;
      exp_stall = i_hold || (!i_branch_taken && m_load_use());
      check("stall", 32'(o_stall), 32'(exp_stall));
      check("flush", 32'(o_flush), 32'(exp_flush));
      check("fwd_a", 32'(o_fwd_a), 32'(m_fwd(m_pipe[0].u1, m_pipe[0].rs1)));
      check("fwd_b", 32'(o_fwd_b), 32'(m_fwd(m_pipe[0].u2, m_pipe[0].rs2)));
      check("stall_cnt", 32'(o_stall_cnt), 32'(m_stall_cnt));
      check("flush_cnt", 32'(o_flush_cnt), 32'(m_flush_cnt));
      check("fwd_mem_load", 32'((o_fwd_a == 2'b01 || o_fwd_b == 2'b01) && m_pipe[1].ld), 32'd0);
   end

   task automatic set_id(input logic v, input int rs1, input logic u1, input int rs2,
                         input logic u2, input int rd, input logic w, input logic ld);
      i_id_valid     = v;
      i_id_rs1       = 5'(rs1);
      i_id_rs1_used  = u1;
      i_id_rs2       = 5'(rs2);
      i_id_rs2_used  = u2;
      i_id_rd        = 5'(rd);
      i_id_reg_write = w;
      i_id_is_load   = ld;
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic samp();
      @(negedge i_clk);
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      i_hold = 1'b0;
      i_branch_taken = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      i_rst_n = 1'b1;
   endtask

   initial begin
      // Reset state
      do_reset();
      samp();
      check("rst_stall", 32'(o_stall), 32'd0);
      check("rst_fwd_a", 32'(o_fwd_a), 32'd0);
      check("rst_stall_cnt", 32'(o_stall_cnt), 32'd0);

      // ALU-to-ALU forwarding from MEM, then from WB
      tick();
      set_id(1, 0, 1, 0, 0, 5, 1, 0);            // addi x5, x0, imm
      tick();
      set_id(1, 5, 1, 5, 1, 6, 1, 0);            // add x6, x5, x5
      tick();
      samp();
      check("t1_fwd_a_mem", 32'(o_fwd_a), 32'd1);
      check("t1_fwd_b_mem", 32'(o_fwd_b), 32'd1);
      set_id(1, 5, 1, 6, 1, 10, 1, 0);           // sub x10, x5, x6
      tick();
      samp();
      check("t1_fwd_a_wb", 32'(o_fwd_a), 32'd2);
      check("t1_fwd_b_mem2", 32'(o_fwd_b), 32'd1);
      set_id(1, 1, 1, 2, 1, 9, 1, 0);            // unrelated add x9, x1, x2
      tick();
      set_id(1, 10, 1, 6, 1, 11, 1, 0);          // consumer of x10 and stale x6
      tick();
      samp();
      check("t1_fwd_a_wb2", 32'(o_fwd_a), 32'd2);
      check("t1_fwd_b_rf", 32'(o_fwd_b), 32'd0);

      // Load-use stall
      do_reset();
      set_id(1, 1, 1, 0, 0, 7, 1, 1);            // lw x7
      tick();
      set_id(1, 1, 1, 7, 1, 8, 1, 0);            // add x8, x1, x7
      samp();
      check("t2_stall", 32'(o_stall), 32'd1);
      tick();
      samp();
      check("t2_stall_gone", 32'(o_stall), 32'd0);
      check("t2_bubble_fwd_b", 32'(o_fwd_b), 32'd0);
      tick();
      samp();
      check("t2_fwd_b_wb", 32'(o_fwd_b), 32'd2);
      check("t2_stall_cnt", 32'(o_stall_cnt), 32'd1);

      // Branch flush coincident with load-use
      do_reset();
      set_id(1, 1, 1, 0, 0, 7, 1, 1);
      tick();
      set_id(1, 7, 1, 0, 0, 8, 1, 0);
      i_branch_taken = 1'b1;
      samp();
      check("t3_flush", 32'(o_flush), 32'd1);
      check("t3_no_stall", 32'(o_stall), 32'd0);
      tick();
      i_branch_taken = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      samp();
      check("t3_flush_cnt", 32'(o_flush_cnt), 32'd1);
      check("t3_stall_cnt", 32'(o_stall_cnt), 32'd0);

      // Hold with a pending branch
      do_reset();
      set_id(1, 0, 1, 0, 0, 5, 1, 0);
      tick();
      set_id(1, 5, 1, 0, 0, 6, 1, 0);
      tick();
      set_id(1, 6, 1, 0, 0, 11, 1, 0);
      i_hold = 1'b1;
      i_branch_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         samp();
         check("t4_hold_stall", 32'(o_stall), 32'd1);
         check("t4_hold_flush", 32'(o_flush), 32'd0);
         check("t4_hold_fwd_a", 32'(o_fwd_a), 32'd1);
         tick();
      end
      i_hold = 1'b0;
      samp();
      check("t4_rel_flush", 32'(o_flush), 32'd1);
      check("t4_rel_fwd_a", 32'(o_fwd_a), 32'd1);
      tick();
      i_branch_taken = 1'b0;
      samp();
      check("t4_flush_once", 32'(o_flush), 32'd0);
      check("t4_flush_cnt", 32'(o_flush_cnt), 32'd1);
      check("t4_stall_cnt", 32'(o_stall_cnt), 32'd0);

      // x0 writers are neither forwarded nor stall sources
      do_reset();
      set_id(1, 1, 1, 0, 0, 0, 1, 1);            // lw x0
      tick();
      set_id(1, 0, 1, 0, 1, 0, 1, 0);            // addi x0 reading x0
      samp();
      check("t5_no_stall", 32'(o_stall), 32'd0);
      tick();
      set_id(1, 0, 1, 0, 1, 1, 1, 0);            // add x1, x0, x0
      tick();
      samp();
      check("t5_fwd_a", 32'(o_fwd_a), 32'd0);
      check("t5_fwd_b", 32'(o_fwd_b), 32'd0);

      // Counter saturation, then reset mid-stall
      do_reset();
      for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
         set_id(1, 0, 1, 0, 0, 7, 1, 1);
         tick();
         set_id(1, 0, 0, 7, 1, 8, 1, 0);
         tick();
      end
      samp();
      check("t6_sat", 32'(o_stall_cnt), 32'd15);
      set_id(1, 0, 1, 0, 0, 7, 1, 1);
      tick();
      set_id(1, 0, 0, 7, 1, 8, 1, 0);
      samp();
      check("t6_pre_rst_stall", 32'(o_stall), 32'd1);
      #1;
      i_rst_n = 1'b0;
      #1;
      check("t6_rst_stall", 32'(o_stall), 32'd0);
      check("t6_rst_stall_cnt", 32'(o_stall_cnt), 32'd0);
      check("t6_rst_flush_cnt", 32'(o_flush_cnt), 32'd0);
      tick();
      i_rst_n = 1'b1;
      samp();
      check("t6_post_rst_stall", 32'(o_stall), 32'd0);
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
